// File: rtl/mm_stream_loader_pkg.sv
// Shared types and sizing helpers for the matrix-multiplier operand loader.
package mm_loader_pkg;

    localparam int unsigned BATCH_W = 16;

    typedef enum logic [2:0] {
        FILL,
        START,
        GAP,
        STREAM,
        WAIT_DONE
    } state_t;

    // One operand set is matrix A followed by matrix B, both M x N.
    function automatic int unsigned total_elems(input int unsigned m, input int unsigned n);
        return 2 * m * n;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/mm_stream_loader_if.sv
// Operand stream in and multiplier start/data/done bus out, bundled for the loader.
interface mm_stream_loader_if #(
    parameter int unsigned DW = 8
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mm_start;
    logic [DW-1:0] mm_data;
    logic          mm_done;

    // master: operand source plus multiplier; slave: the loader itself
    modport master (
        output in_data, in_valid, mm_done,
        input  in_ready, mm_start, mm_data
    );

    modport slave (
        input  in_data, in_valid, mm_done,
        output in_ready, mm_start, mm_data
    );
endinterface

// File: rtl/mm_stream_loader_elem_buf.sv
// Element buffer: TOTAL x DW register array, synchronous write, registered read output.
module mm_elem_buf #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value between streams, so mm_data keeps the last element.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mm_stream_loader.sv
// Buffers one A+B operand set and replays it to the multiplier as start, gap, stream.
// Optional done-watchdog and err_timeout output when MM_LOADER_TIMEOUT_EN is defined.
module mm_stream_loader
    import mm_loader_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned M       = 2,
    parameter int unsigned N       = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    mm_stream_loader_if.slave  bus,
    output logic               busy,
    output logic [BATCH_W-1:0] batch_cnt
`ifdef MM_LOADER_TIMEOUT_EN
    ,
    output logic               err_timeout
`endif
);

    localparam int unsigned TOTAL = total_elems(M, N);
    localparam int unsigned PW    = ptr_width(TOTAL);

    localparam logic [PW-1:0] WR_LAST = PW'(TOTAL - 1);
    localparam logic [PW:0]   RD_LAST = (PW + 1)'(TOTAL - 1);
    localparam logic [PW:0]   RD_END  = (PW + 1)'(TOTAL);

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          full;

    logic          in_ready;
    logic          mm_start;
    logic          accept;
    logic          rd_en;
    logic          stream_end;
    logic          wait_exit;

    assign accept     = bus.in_valid && in_ready;
    assign stream_end = (state == STREAM) && (rd_ptr == RD_END);

`ifdef MM_LOADER_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        timeout_hit;

    assign timeout_hit = (state == WAIT_DONE) && (wd_cnt == 32'(TIMEOUT - 1));
    assign wait_exit   = bus.mm_done || timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (stream_end) begin
                wd_cnt <= '0;
            end else if (state == WAIT_DONE) begin
                wd_cnt <= wd_cnt + 32'd1;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign wait_exit = bus.mm_done;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the exit from WAIT_DONE looks at the registered full flag,
    // so a done coinciding with the final refill accept detours through FILL.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:      if (full) state_nxt = START;
            START:     state_nxt = GAP;
            GAP:       state_nxt = STREAM;
            STREAM:    if (rd_ptr == RD_END) state_nxt = WAIT_DONE;
            WAIT_DONE: if (wait_exit) state_nxt = full ? START : FILL;
            default:   state_nxt = FILL;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        mm_start = 1'b0;
        busy     = 1'b1;
        in_ready = 1'b0;
        rd_en    = 1'b0;
        case (state)
            FILL: begin
                busy     = 1'b0;
                in_ready = !full;
            end
            START:     mm_start = 1'b1;
            GAP:       rd_en = 1'b1;
            STREAM:    rd_en = (rd_ptr != RD_END);
            WAIT_DONE: in_ready = !full;
            default:   busy = 1'b0;
        endcase
    end

    assign bus.in_ready = in_ready;
    assign bus.mm_start = mm_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            full   <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == WR_LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (accept && (wr_ptr == WR_LAST)) begin
                full <= 1'b1;
            end else if (rd_en && (rd_ptr == RD_LAST)) begin
                full <= 1'b0;
            end
        end
    end

    // rd_ptr runs one ahead of the element on mm_data and reaches TOTAL on the last stream cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (state == START) begin
            rd_ptr <= '0;
        end else if (rd_en) begin
            rd_ptr <= rd_ptr + (PW + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            batch_cnt <= '0;
        end else if (stream_end) begin
            batch_cnt <= batch_cnt + BATCH_W'(1);
        end
    end

    mm_elem_buf #(
        .DEPTH (TOTAL),
        .DW    (DW),
        .AW    (PW)
    ) u_elem_buf (
        .clk   (clk),
        .reset (reset),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .re    (rd_en),
        .raddr (rd_ptr[PW-1:0]),
        .rdata (bus.mm_data)
    );

endmodule

// File: tb/tb_mm_stream_loader.sv
// Directed-sequence bench for mm_stream_loader with random operand sets and a set-level model.
module tb_mm_stream_loader;

    localparam int unsigned DW    = 8;
    localparam int unsigned M     = 2;
    localparam int unsigned N     = 2;
    localparam int unsigned TOTAL = 2 * M * N;
    localparam int unsigned TMO   = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [15:0] batch_cnt;
`ifdef MM_LOADER_TIMEOUT_EN
    logic        err_timeout;
`endif

    mm_stream_loader_if #(.DW(DW)) bus ();

    mm_stream_loader #(
        .DW      (DW),
        .M       (M),
        .N       (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .batch_cnt (batch_cnt)
`ifdef MM_LOADER_TIMEOUT_EN
        ,
        .err_timeout (err_timeout)
`endif
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [DW-1:0] set_q [TOTAL];
    logic [DW-1:0] last_data;
    logic [15:0]   exp_batch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_set();
        for (int unsigned i = 0; i < TOTAL; i++) set_q[i] = DW'($urandom);
    endtask

    // Offer set_q[from..to-1]; with toggle, an idle cycle precedes every element after the first.
    task automatic feed(input int unsigned from, input int unsigned to, input bit toggle);
        for (int unsigned i = from; i < to; i++) begin
            if (toggle && i != from) begin
                bus.in_valid = 1'b0;
                bus.in_data  = DW'($urandom);
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = set_q[i];
            check("in_ready_open", 32'(bus.in_ready), 1);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_done();
        bus.mm_done = 1'b1;
        tick();
        bus.mm_done = 1'b0;
    endtask

    // Entered on the START cycle; leaves on the first WAIT_DONE cycle.
    task automatic stream_check();
        check("start_pulse", 32'(bus.mm_start), 1);
        check("busy_start", 32'(busy), 1);
        check("in_ready_start", 32'(bus.in_ready), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        tick();
        check("gap_start_low", 32'(bus.mm_start), 0);
        check("gap_data_hold", 32'(bus.mm_data), 32'(last_data));
        tick();
        for (int unsigned k = 0; k < TOTAL; k++) begin
            check("stream_data", 32'(bus.mm_data), 32'(set_q[k]));
            check("stream_start_low", 32'(bus.mm_start), 0);
            check("stream_in_ready", 32'(bus.in_ready), 0);
            if (k == TOTAL - 1) bus.in_valid = 1'b0;
            tick();
        end
        exp_batch = exp_batch + 16'd1;
        last_data = set_q[TOTAL-1];
        check("batch_cnt", 32'(batch_cnt), 32'(exp_batch));
        check("wait_data_hold", 32'(bus.mm_data), 32'(last_data));
        check("wait_in_ready", 32'(bus.in_ready), 1);
        check("wait_busy", 32'(busy), 1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.mm_done  = 1'b0;
        reset        = 1'b1;
        exp_batch    = '0;
        last_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mm_start", 32'(bus.mm_start), 0);
        check("rst_mm_data", 32'(bus.mm_data), 0);
        check("rst_batch", 32'(batch_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        reset = 1'b0;
        tick();

        // Back-to-back fixed set
        set_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1};
        feed(0, TOTAL, 1'b0);
        check("full_in_ready", 32'(bus.in_ready), 0);
        check("full_start_low", 32'(bus.mm_start), 0);
        check("full_busy", 32'(busy), 0);
        tick();
        stream_check();

        // Refill during WAIT_DONE, then release with done
        set_q = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd8, 8'd7, 8'd6, 8'd5};
        feed(0, TOTAL, 1'b0);
        check("refill_in_ready", 32'(bus.in_ready), 0);
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check("wait_no_start", 32'(bus.mm_start), 0);
        end
        pulse_done();
        stream_check();

        // Done with empty buffer returns to FILL; then a toggled-valid feed
        pulse_done();
        check("fill_busy", 32'(busy), 0);
        check("fill_in_ready", 32'(bus.in_ready), 1);
        check("fill_data_hold", 32'(bus.mm_data), 32'(last_data));
        new_set();
        feed(0, TOTAL, 1'b1);
        check("toggle_full_ready", 32'(bus.in_ready), 0);
        tick();
        stream_check();

        // Done inside FILL after three accepts is ignored
        pulse_done();
        new_set();
        feed(0, 3, 1'b0);
        pulse_done();
        for (int unsigned i = 0; i < 4; i++) begin
            check("fill_done_no_start", 32'(bus.mm_start), 0);
            check("fill_done_busy", 32'(busy), 0);
            check("fill_done_ready", 32'(bus.in_ready), 1);
            tick();
        end
        feed(3, TOTAL, 1'b0);
        tick();
        stream_check();

        // Final refill accept coincides with done: one FILL bubble before START
        new_set();
        feed(0, TOTAL - 1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = set_q[TOTAL-1];
        bus.mm_done  = 1'b1;
        check("coinc_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        bus.mm_done  = 1'b0;
        check("bubble_busy", 32'(busy), 0);
        check("bubble_ready", 32'(bus.in_ready), 0);
        check("bubble_start", 32'(bus.mm_start), 0);
        tick();
        stream_check();

        // Reset at stream cycle 4 discards the set
        pulse_done();
        new_set();
        feed(0, TOTAL, 1'b0);
        tick();
        check("pre_rst_start", 32'(bus.mm_start), 1);
        tick();
        tick();
        check("pre_rst_stream0", 32'(bus.mm_data), 32'(set_q[0]));
        repeat (4) tick();
        check("pre_rst_stream4", 32'(bus.mm_data), 32'(set_q[4]));
        reset = 1'b1;
        #1;
        check("midrst_start", 32'(bus.mm_start), 0);
        check("midrst_data", 32'(bus.mm_data), 0);
        check("midrst_batch", 32'(batch_cnt), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ready", 32'(bus.in_ready), 1);
        exp_batch = '0;
        last_data = '0;
        tick();
        reset = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check("postrst_no_start", 32'(bus.mm_start), 0);
            check("postrst_busy", 32'(busy), 0);
        end
        new_set();
        feed(0, TOTAL, 1'b0);
        tick();
        stream_check();

`ifdef MM_LOADER_TIMEOUT_EN
        check("tmo_clear", 32'(err_timeout), 0);
        for (int unsigned n = 1; n < TMO; n++) begin
            tick();
            check("tmo_pending", 32'(err_timeout), 0);
            check("tmo_busy", 32'(busy), 1);
        end
        tick();
        check("tmo_set", 32'(err_timeout), 1);
        check("tmo_to_fill", 32'(busy), 0);
        check("tmo_ready", 32'(bus.in_ready), 1);
        repeat (3) tick();
        check("tmo_sticky", 32'(err_timeout), 1);
`else
        repeat (30) tick();
        check("wait_forever_busy", 32'(busy), 1);
        check("wait_forever_ready", 32'(bus.in_ready), 1);
        check("wait_forever_start", 32'(bus.mm_start), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm_stream_loader.md
Name: mm_stream_loader

Overview:
Upstream feeder for the matrix multiplier. It accepts operand elements over a valid/ready stream and buffers one complete operand set: matrix A (M*N elements) followed by matrix B (M*N elements). It then drives the multiplier's start/data_in protocol: a one-cycle start pulse, a one-cycle gap, then one element per clock. It waits for the multiplier's done before issuing the next set, and refills its buffer while the multiplier computes.

Parameters:
DW, 8, element width in bits
M, 2, matrix rows
N, 2, matrix columns; TOTAL = 2*M*N elements per set; PW = $clog2(TOTAL)
TIMEOUT, 4096, done-watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_data  in  DW  operand element, row-major, A then B
in_valid  in  1  in_data valid
in_ready  out  1  loader can accept; transfer when in_valid && in_ready
mm_start  out  1  start pulse to the multiplier
mm_data  out  DW  element to the multiplier's data_in
mm_done  in  1  multiplier completion pulse
busy  out  1  high in every state except FILL
batch_cnt  out  16  count of sets issued; wraps at 65535 -> 0

Behaviour:
- Reset (async assert, sync release) sets:
  - state = FILL; wr_ptr = rd_ptr = 0; full = 0.
  - mm_start = 0, mm_data = 0, batch_cnt = 0, busy = 0.
  - Buffer contents are don't-care.
- in_ready = (state == FILL || state == WAIT_DONE) && !full. This is combinational from registered state.
- Accept: buf[wr_ptr] <= in_data; wr_ptr increments. On the TOTAL-th accept, wr_ptr wraps to 0 and full <= 1.
- FILL: when full (registered), go to START. The first mm_start is therefore the cycle after the edge that set full.
- START: mm_start = 1 for exactly one cycle. Next state is GAP.
- GAP: mm_start = 0; mm_data holds its prior value. Next state is STREAM; rd_ptr = 0.
- STREAM: lasts exactly TOTAL cycles.
  - mm_data is registered; during stream cycle k it equals buf[k].
  - The edge leaving GAP loads buf[0].
  - full is cleared on the edge that loads buf[TOTAL-1].
  - Next state is WAIT_DONE; batch_cnt increments on that same edge.
- After STREAM, mm_data holds the last element until the next STREAM.
- WAIT_DONE:
  - Accepts allowed (refill of the next set).
  - On mm_done: go to START if full, else FILL.
  - mm_done and the final refill accept in the same cycle: full is set on that edge and the state goes to FILL. FILL then exits to START on the next cycle (one-cycle bubble, accepted).
- mm_done outside WAIT_DONE is ignored.
- in_valid with in_ready low: no write; the source must hold its data.
- Reset mid-STREAM or mid-WAIT_DONE aborts immediately. The partial set is discarded and no start is issued.

Optional Feature:
Macro MM_LOADER_TIMEOUT_EN.
- Defined:
  - Adds output err_timeout (1 bit, reset 0) and a 32-bit watchdog counter.
  - The counter clears on entry to WAIT_DONE and increments each cycle in WAIT_DONE.
  - Reaching TIMEOUT: err_timeout sets (sticky until reset). The state goes to START if full, else FILL, as if done had arrived.
- Undefined:
  - No port, no counter.
  - WAIT_DONE waits indefinitely.

Decomposition:
- Package mm_loader_pkg holds:
  - state enum {FILL, START, GAP, STREAM, WAIT_DONE};
  - the TOTAL/PW derivation function;
  - the batch counter width constant (16).
- One sub-module: mm_elem_buf, a TOTAL x DW simple dual-port register array with a synchronous write port and a read port registered into mm_data.
- Pointers, full flag and FSM stay in the top module.

Test Plan:
- Back-to-back feed (M=N=2, DW=8) of 1,2,3,4,4,3,2,1 -> in_ready drops after the 8th accept; mm_start is high for exactly one cycle; the gap cycle follows; mm_data reads 1,2,3,4,4,3,2,1 on 8 consecutive cycles; batch_cnt = 1.
- Same data with in_valid toggled 1,0,1,0 -> no duplicated or dropped elements; identical mm_data sequence; start is delayed accordingly.
- Refill during WAIT_DONE: feed 5,6,7,8,8,7,6,5 before mm_done -> in_ready goes low after 8 accepts; mm_done pulse gives mm_start on the next cycle; second stream is 5,6,7,8,8,7,6,5; batch_cnt = 2.
- mm_done pulsed in FILL after 3 accepts -> ignored; state stays FILL; no mm_start.
- reset asserted at stream cycle 4 -> outputs go to reset values in the same cycle; after release, in_ready = 1 and the next 8 accepts produce a clean stream.
- With MM_LOADER_TIMEOUT_EN and TIMEOUT = 20, mm_done never asserted -> err_timeout = 1 after 20 WAIT_DONE cycles; state returns to FILL; err_timeout stays high.
